// File: rtl/mmio_responder.sv
// MMIO target beside data BRAM: UART TX/RX FIFOs, cycle counter, retired-instruction counter.
// Build option: define MMIO_OVERFLOW_STATUS_EN for a sticky TX-overflow flag in STATUS bit2.
module mmio_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADR   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_adr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  wea,
  input  logic        instr_valid,
  output logic [31:0] dout,
  output logic        mmio_hit,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [29:0] BASE_W = BASE_ADR[31:2];
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Address decode
  logic [29:0] word_off;
  logic        sel_status, sel_rx, sel_tx, sel_cycle, sel_instr, sel_cnt_rst;
  logic        reg_match, is_read;

  // FIFO state
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]  rx_head;

  // Counters and read path
  logic [31:0] cycle_cnt, instr_cnt;
  logic        cnt_rst;
  logic        ovf_bit;
  logic [31:0] status_word, rd_data;

  // Unused address/data bits, gathered so the intent is explicit.
  logic unused_bits;
  assign unused_bits = ^{mem_adr[1:0], mem_wdata[31:8]};

  assign word_off = mem_adr[31:2] - BASE_W;
  assign is_read  = (wea == 4'b0000);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    sel_status  = 1'b0;
    sel_rx      = 1'b0;
    sel_tx      = 1'b0;
    sel_cycle   = 1'b0;
    sel_instr   = 1'b0;
    sel_cnt_rst = 1'b0;
    case (word_off)
      30'h0:   sel_status  = 1'b1;
      30'h1:   sel_rx      = 1'b1;
      30'h2:   sel_tx      = 1'b1;
      30'h4:   sel_cycle   = 1'b1;
      30'h5:   sel_instr   = 1'b1;
      30'h6:   sel_cnt_rst = 1'b1;
      default: ;
    endcase
  end

  assign reg_match = sel_status | sel_rx | sel_tx | sel_cycle | sel_instr | sel_cnt_rst;

  // Full when pointers differ only in the wrap bit; empty when identical.
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) && (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
  assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) && (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);

  assign uart_tx_valid = ~tx_empty;
  assign uart_rx_ready = ~rx_full;
  assign uart_tx_data  = tx_mem[tx_rd_ptr[AW-1:0]];
  assign rx_head       = rx_mem[rx_rd_ptr[AW-1:0]];

  // A same-cycle pop frees the slot, so a push into a full TX FIFO still lands.
  assign tx_pop      = ~tx_empty & uart_tx_ready;
  assign tx_push_req = sel_tx & wea[0];
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign rx_push     = uart_rx_valid & ~rx_full;
  assign rx_pop      = sel_rx & is_read & ~rx_empty;
  assign cnt_rst     = sel_cnt_rst & (|wea);

`ifdef MMIO_OVERFLOW_STATUS_EN
  logic tx_ovf;
  logic tx_overflow, ovf_clr;

  assign tx_overflow = tx_push_req & tx_full & ~tx_pop;
  assign ovf_clr     = sel_status & wea[0] & mem_wdata[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            tx_ovf <= 1'b0;
    else if (tx_overflow) tx_ovf <= 1'b1;
    else if (ovf_clr)     tx_ovf <= 1'b0;
  end

  assign ovf_bit = tx_ovf;
`else
  assign ovf_bit = 1'b0;
`endif

  assign status_word = {29'd0, ovf_bit, ~rx_empty, ~tx_full};

  always_comb begin
    rd_data = '0;
    if (sel_status)           rd_data = status_word;
    if (sel_rx && !rx_empty)  rd_data = {24'd0, rx_head};
    if (sel_cycle)            rd_data = cycle_cnt;
    if (sel_instr)            rd_data = instr_cnt;
  end

  // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= mem_wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= uart_rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
    end
  end

  // Counter reset takes priority over the increment of the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cnt_rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      instr_cnt <= instr_cnt + {31'd0, instr_valid};
    end
  end

  // Registered response: data for a read in cycle N appears in cycle N+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout     <= '0;
      mmio_hit <= 1'b0;
    end else begin
      mmio_hit <= is_read & reg_match;
      dout     <= (is_read & reg_match) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed vector table, counter/overflow/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_mmio_responder;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef MMIO_OVERFLOW_STATUS_EN
  localparam logic [31:0] OVF_BIT = 32'h4;
`else
  localparam logic [31:0] OVF_BIT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_adr, mem_wdata;
  logic [3:0]  wea;
  logic        instr_valid;
  logic [31:0] dout;
  logic        mmio_hit;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, uart_rx_ready;

  mmio_responder #(.FIFO_DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
    .clk(clk), .reset(reset),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .wea(wea), .instr_valid(instr_valid),
    .dout(dout), .mmio_hit(mmio_hit),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: FIFOs as queues, counters as plain integers.
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] m_cyc, m_ins, m_dout;
  logic        m_ovf, m_hit;

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_cyc = 0; m_ins = 0; m_ovf = 0; m_dout = 0; m_hit = 0;
  endtask

  task automatic model_step();
    logic [31:0] off;
    bit rd, known, tx_pop, rx_take, overflow;
    off      = {mem_adr[31:2], 2'b00} - BASE;
    rd       = (wea == 4'b0000);
    known    = off inside {32'h0, 32'h4, 32'h8, 32'h10, 32'h14, 32'h18};
    tx_pop   = (tx_q.size() != 0) && uart_tx_ready;
    rx_take  = uart_rx_valid && (rx_q.size() < DEPTH);
    overflow = 0;
    m_hit  = rd && known;
    m_dout = 0;
    if (m_hit) begin
      case (off)
        32'h0:  m_dout = {29'd0, m_ovf, rx_q.size() != 0, tx_q.size() < DEPTH};
        32'h4:  if (rx_q.size() != 0) m_dout = {24'd0, rx_q[0]};
        32'h10: m_dout = m_cyc;
        32'h14: m_dout = m_ins;
        default: m_dout = 0;
      endcase
    end
    if (rd && off == 32'h4 && rx_q.size() != 0) void'(rx_q.pop_front());
    if (rx_take) rx_q.push_back(uart_rx_data);
    if (tx_pop) void'(tx_q.pop_front());
    if (wea[0] && off == 32'h8) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(mem_wdata[7:0]);
      else overflow = 1;
    end
`ifdef MMIO_OVERFLOW_STATUS_EN
    if (wea[0] && off == 32'h0 && mem_wdata[2]) m_ovf = 0;
    if (overflow) m_ovf = 1;
`endif
    if (off == 32'h18 && wea != 4'b0000) begin
      m_cyc = 0;
      m_ins = 0;
    end else begin
      m_cyc = m_cyc + 1;
      m_ins = m_ins + 32'(instr_valid);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    mem_adr = a; mem_wdata = d; wea = w;
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        hit;
    logic [31:0] dout;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        rx_ready;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] offs[8];
    logic [3:0]  weas[6];
    offs = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h14, 32'h18, 32'hC, 32'h1C};
    weas = '{4'h0, 4'h0, 4'h0, 4'h1, 4'hF, 4'h2};

    //                adr           wdata  wea   rxv rxd    txr  hit dout   txv txd    rxr
    vecs[0]  = '{32'h8000_0000, 32'h0,  4'h0, 0, 8'h00, 0,  1, 32'h1,  0, 8'h00, 1};
    vecs[1]  = '{32'h8000_0008, 32'h41, 4'h1, 0, 8'h00, 0,  0, 32'h0,  1, 8'h41, 1};
    vecs[2]  = '{32'h0,         32'h0,  4'h0, 0, 8'h00, 0,  0, 32'h0,  1, 8'h41, 1};
    vecs[3]  = '{32'h0,         32'h0,  4'h0, 0, 8'h00, 1,  0, 32'h0,  0, 8'h00, 1};
    vecs[4]  = '{32'h8000_0008, 32'h99, 4'h2, 0, 8'h00, 0,  0, 32'h0,  0, 8'h00, 1};
    vecs[5]  = '{32'h0,         32'h0,  4'h0, 1, 8'h55, 0,  0, 32'h0,  0, 8'h00, 1};
    vecs[6]  = '{32'h0,         32'h0,  4'h0, 1, 8'hAA, 0,  0, 32'h0,  0, 8'h00, 1};
    vecs[7]  = '{32'h8000_0004, 32'h0,  4'h0, 0, 8'h00, 0,  1, 32'h55, 0, 8'h00, 1};
    vecs[8]  = '{32'h8000_0004, 32'h0,  4'h0, 0, 8'h00, 0,  1, 32'hAA, 0, 8'h00, 1};
    vecs[9]  = '{32'h8000_0000, 32'h0,  4'h0, 0, 8'h00, 0,  1, 32'h1,  0, 8'h00, 1};
    vecs[10] = '{32'h8000_0004, 32'h0,  4'h0, 0, 8'h00, 0,  1, 32'h0,  0, 8'h00, 1};
    vecs[11] = '{32'h1000_0000, 32'h0,  4'h0, 0, 8'h00, 0,  0, 32'h0,  0, 8'h00, 1};
    vecs[12] = '{32'h8000_0003, 32'h0,  4'h0, 0, 8'h00, 0,  1, 32'h1,  0, 8'h00, 1};
    vecs[13] = '{32'h8000_0000, 32'h0,  4'hF, 0, 8'h00, 0,  0, 32'h0,  0, 8'h00, 1};

    reset = 1'b1;
    drive(32'h0, 32'h0, 4'h0);
    instr_valid = 0; uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = 0;
    model_reset();
    #22;
    check("rst_hit", 32'(mmio_hit), 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_txv", 32'(uart_tx_valid), 32'h0);
    check("rst_rxr", 32'(uart_rx_ready), 32'h1);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].adr, vecs[i].wdata, vecs[i].wea);
      uart_rx_valid = vecs[i].rx_valid;
      uart_rx_data  = vecs[i].rx_data;
      uart_tx_ready = vecs[i].tx_ready;
      tick();
      check($sformatf("vec%0d_hit", i), 32'(mmio_hit), 32'(vecs[i].hit));
      check($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
      check($sformatf("vec%0d_txv", i), 32'(uart_tx_valid), 32'(vecs[i].tx_valid));
      if (vecs[i].tx_valid) check($sformatf("vec%0d_txd", i), 32'(uart_tx_data), 32'(vecs[i].tx_data));
      check($sformatf("vec%0d_rxr", i), 32'(uart_rx_ready), 32'(vecs[i].rx_ready));
    end
    uart_rx_valid = 0; uart_tx_ready = 0;

    // Counters: clear (beats a same-cycle instr_valid), count 100 cycles with 60 retirements
    drive(32'h8000_0018, 32'h0, 4'b0100); instr_valid = 1; tick();
    check("cntrst_hit", 32'(mmio_hit), 32'h0);
    drive(32'h8000_0014, 32'h0, 4'h0); instr_valid = 0; tick();
    check("instr_after_rst", dout, 32'd0);
    drive(32'h8000_0010, 32'h0, 4'h0); tick();
    check("cycle_after_rst", dout, 32'd1);
    drive(32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 100; i++) begin
      instr_valid = (i < 60);
      tick();
    end
    instr_valid = 0;
    drive(32'h8000_0010, 32'h0, 4'h0); tick();
    check("cycle_delta", dout, 32'd102);
    drive(32'h8000_0014, 32'h0, 4'h0); tick();
    check("instr_delta", dout, 32'd60);
    drive(32'h8000_0010, 32'hDEAD_BEEF, 4'hF); tick();
    check("wr_cycle_hit", 32'(mmio_hit), 32'h0);
    check("wr_cycle_dout", dout, 32'h0);
    drive(32'h8000_0010, 32'h0, 4'h0); tick();
    check("cycle_unchanged_by_write", dout, 32'd105);

    // TX overflow: 8 pushes fill, 9th is dropped
    uart_tx_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drive(32'h8000_0008, 32'h10 + 32'(i), 4'h1); tick();
    end
    drive(32'h8000_0000, 32'h0, 4'h0); tick();
    check("full_status", dout, 32'h0);
    drive(32'h8000_0008, 32'h18, 4'h1); tick();
    drive(32'h8000_0000, 32'h0, 4'h0); tick();
    check("ovf_status", dout, OVF_BIT);
    tick();
    check("ovf_sticky", dout, OVF_BIT);
    drive(32'h8000_0000, 32'h4, 4'h1); tick();
    drive(32'h8000_0000, 32'h0, 4'h0); tick();
    check("ovf_cleared", dout, 32'h0);
    drive(32'h0, 32'h0, 4'h0);
    uart_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_txv", i), 32'(uart_tx_valid), 32'h1);
      check($sformatf("drain%0d_txd", i), 32'(uart_tx_data), 32'h10 + 32'(i));
      tick();
    end
    check("drained_txv", 32'(uart_tx_valid), 32'h0);

    // Asynchronous reset in the middle of a TX transfer
    uart_tx_ready = 0;
    drive(32'h8000_0008, 32'hA1, 4'h1); tick();
    drive(32'h8000_0008, 32'hA2, 4'h1); uart_rx_valid = 1; uart_rx_data = 8'h3C; tick();
    uart_rx_valid = 0;
    drive(32'h8000_0000, 32'h0, 4'h0); tick();
    check("pre_rst_hit", 32'(mmio_hit), 32'h1);
    check("pre_rst_status", dout, 32'h3);
    drive(32'h0, 32'h0, 4'h0); uart_tx_ready = 1;
    #2 reset = 1'b1;
    #1;
    check("midrst_txv", 32'(uart_tx_valid), 32'h0);
    check("midrst_rxr", 32'(uart_rx_ready), 32'h1);
    check("midrst_hit", 32'(mmio_hit), 32'h0);
    check("midrst_dout", dout, 32'h0);
    model_reset();
    #2 reset = 1'b0;
    uart_tx_ready = 0;
    drive(32'h8000_0010, 32'h0, 4'h0); tick();
    check("postrst_cycle", dout, 32'h0);
    drive(32'h8000_0000, 32'h0, 4'h0); tick();
    check("postrst_status", dout, 32'h1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 8)       mem_adr = BASE + offs[r] + 32'($urandom_range(0, 3));
      else if (r == 8) mem_adr = 32'h1000_0000;
      else             mem_adr = 32'h0;
      mem_wdata     = $urandom;
      wea           = weas[$urandom_range(0, 5)];
      instr_valid   = 1'($urandom_range(0, 1));
      uart_rx_valid = ($urandom_range(0, 3) != 0);
      uart_rx_data  = 8'($urandom);
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      tick();
      check("rnd_hit", 32'(mmio_hit), 32'(m_hit));
      check("rnd_dout", dout, m_dout);
      check("rnd_txv", 32'(uart_tx_valid), 32'(tx_q.size() != 0));
      if (tx_q.size() != 0) check("rnd_txd", 32'(uart_tx_data), 32'(tx_q[0]));
      check("rnd_rxr", 32'(uart_rx_ready), 32'(rx_q.size() < DEPTH));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
